// File: rtl/rx_reset_sm_ch.sv
// Per-channel RX reset sequencer: releases the RX SERDES and PCS resets only after
// PLL lock, then CDR lock with signal present, each qualified by a hold timer.
module rx_reset_sm_ch #(
   parameter int T1_BIT = 2,
   parameter int T2_BIT = 16
) (
   input  logic refclkdiv2,
   input  logic rst_n,
   input  logic tx_pll_lol_qd,
   input  logic rx_cdr_lol_ch,
   input  logic rx_los_low_ch,
   output logic rx_serdes_rst_ch_c,
   output logic rx_pcs_rst_ch_c
);

   typedef enum logic [2:0] {
      WAIT_PLOL  = 3'd0,
      SERDES_RST = 3'd1,
      WAIT_T1    = 3'd2,
      CHECK      = 3'd3,
      WAIT_T2    = 3'd4,
      NORMAL     = 3'd5
   } state_t;

   // cs_q is a plain vector so an unencoded value can be held and recovered from.
   logic [2:0]      cs_q;
   state_t          cs_d;
   logic [1:0]      plol_sync_q, plol_sync_d;
   logic [1:0]      cdr_sync_q, cdr_sync_d;
   logic [1:0]      los_sync_q, los_sync_d;
   logic            lol_los_dly_q, lol_los_dly_d;
   logic [T1_BIT:0] timer1_q, timer1_d;
   logic [T2_BIT:0] timer2_q, timer2_d;
   logic            serdes_rst_q, serdes_rst_d;
   logic            pcs_rst_q, pcs_rst_d;

   logic plol;
   logic los;
   logic lol_los;
   logic lol_los_chg;

   assign plol        = plol_sync_q[1];
   assign los         = los_sync_q[1];
   assign lol_los     = cdr_sync_q[1] | los_sync_q[1];
   assign lol_los_chg = lol_los != lol_los_dly_q;

   always_comb begin
      plol_sync_d   = {plol_sync_q[0], tx_pll_lol_qd};
      cdr_sync_d    = {cdr_sync_q[0], rx_cdr_lol_ch};
      los_sync_d    = {los_sync_q[0], rx_los_low_ch};
      lol_los_dly_d = lol_los;
   end

   // Timers count freely, saturate on their terminal bit and clear in the state before use.
   always_comb begin
      timer1_d = timer1_q;
      if (cs_q == SERDES_RST)
         timer1_d = '0;
      else if (!timer1_q[T1_BIT])
         timer1_d = timer1_q + {{T1_BIT{1'b0}}, 1'b1};

      timer2_d = timer2_q;
      if (cs_q == CHECK)
         timer2_d = '0;
      else if (!timer2_q[T2_BIT])
         timer2_d = timer2_q + {{T2_BIT{1'b0}}, 1'b1};
   end

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      cs_d = WAIT_PLOL;
      if (plol && cs_q != WAIT_PLOL) begin
         cs_d = WAIT_PLOL;
      end else begin
         case (cs_q)
            WAIT_PLOL:  cs_d = (!plol && !los) ? SERDES_RST : WAIT_PLOL;
            SERDES_RST: cs_d = WAIT_T1;
            WAIT_T1:    cs_d = timer1_q[T1_BIT] ? CHECK : WAIT_T1;
            CHECK:      cs_d = WAIT_T2;
            WAIT_T2: begin
               if (lol_los_chg)
                  cs_d = CHECK;
               else if (timer2_q[T2_BIT])
                  cs_d = lol_los ? WAIT_PLOL : NORMAL;
               else
                  cs_d = WAIT_T2;
            end
            NORMAL:     cs_d = lol_los ? WAIT_PLOL : NORMAL;
            default:    cs_d = WAIT_PLOL;
         endcase
      end
   end

   always_comb begin
      serdes_rst_d = 1'b0;
      pcs_rst_d    = 1'b1;
      case (cs_q)
         SERDES_RST, WAIT_T1: serdes_rst_d = 1'b1;
         NORMAL:              pcs_rst_d    = 1'b0;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge refclkdiv2 or negedge rst_n) begin
      if (!rst_n) begin
         cs_q          <= WAIT_PLOL;
         plol_sync_q   <= 2'b11;
         cdr_sync_q    <= 2'b11;
         los_sync_q    <= 2'b11;
         lol_los_dly_q <= 1'b1;
         timer1_q      <= '0;
         timer2_q      <= '0;
         serdes_rst_q  <= 1'b0;
         pcs_rst_q     <= 1'b1;
      end else begin
         cs_q          <= cs_d;
         plol_sync_q   <= plol_sync_d;
         cdr_sync_q    <= cdr_sync_d;
         los_sync_q    <= los_sync_d;
         lol_los_dly_q <= lol_los_dly_d;
         timer1_q      <= timer1_d;
         timer2_q      <= timer2_d;
         serdes_rst_q  <= serdes_rst_d;
         pcs_rst_q     <= pcs_rst_d;
      end
   end

   assign rx_serdes_rst_ch_c = serdes_rst_q;
   assign rx_pcs_rst_ch_c    = pcs_rst_q;

endmodule

// File: tb/tb_rx_reset_sm_ch.sv
// Bench for rx_reset_sm_ch: vector table, timed corner-case sequences, and a
// randomized run against a phase/duration model of the reset sequence.
module tb_rx_reset_sm_ch;

   localparam int T1_BIT = 2;
   localparam int T2_BIT = 4;
   localparam int NT     = 100;
   localparam int T1_LEN = (1 << T1_BIT) + 1;
   localparam int T2_LEN = (1 << T2_BIT) + 1;

   logic refclkdiv2 = 1'b0;
   logic rst_n;
   logic tx_pll_lol_qd;
   logic rx_cdr_lol_ch;
   logic rx_los_low_ch;
   logic rx_serdes_rst_ch_c;
   logic rx_pcs_rst_ch_c;

   int total = 0;
   int bad   = 0;

   logic sd_tr [0:NT-1];
   logic pc_tr [0:NT-1];

   always #5 refclkdiv2 = ~refclkdiv2;

   rx_reset_sm_ch #(.T1_BIT(T1_BIT), .T2_BIT(T2_BIT)) dut (
      .refclkdiv2         (refclkdiv2),
      .rst_n              (rst_n),
      .tx_pll_lol_qd      (tx_pll_lol_qd),
      .rx_cdr_lol_ch      (rx_cdr_lol_ch),
      .rx_los_low_ch      (rx_los_low_ch),
      .rx_serdes_rst_ch_c (rx_serdes_rst_ch_c),
      .rx_pcs_rst_ch_c    (rx_pcs_rst_ch_c)
   );

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclkdiv2);
      @(negedge refclkdiv2);
   endtask

   // Reset, release at k=0, then record outputs after each edge k. The PLL/CDR raw inputs
   // are high for k in [lo,hi]; cdr_lo==0 means CDR already unlocked during reset.
   task automatic run_seq(input int n, input int pll_lo, input int pll_hi,
                          input int cdr_lo, input int cdr_hi);
      rst_n         = 1'b0;
      tx_pll_lol_qd = 1'b0;
      rx_cdr_lol_ch = (cdr_lo == 0);
      rx_los_low_ch = 1'b0;
      tick();
      tick();
      rst_n    = 1'b1;
      sd_tr[0] = rx_serdes_rst_ch_c;
      pc_tr[0] = rx_pcs_rst_ch_c;
      for (int k = 1; k <= n; k++) begin
         tx_pll_lol_qd = (k >= pll_lo && k <= pll_hi);
         rx_cdr_lol_ch = (k >= cdr_lo && k <= cdr_hi);
         tick();
         sd_tr[k] = rx_serdes_rst_ch_c;
         pc_tr[k] = rx_pcs_rst_ch_c;
      end
   endtask

   function automatic int count_hi(input int a, input int b);
      int c = 0;
      for (int k = a; k <= b; k++) if (sd_tr[k] === 1'b1) c++;
      return c;
   endfunction

   function automatic int first_rise(input int from, input int to);
      for (int k = from; k <= to; k++)
         if (sd_tr[k] === 1'b1 && sd_tr[k-1] === 1'b0) return k;
      return -1;
   endfunction

   function automatic int first_pcs_low(input int to);
      for (int k = 1; k <= to; k++) if (pc_tr[k] === 1'b0) return k;
      return -1;
   endfunction

   typedef struct {
      logic rst_n;
      logic pll;
      logic cdr;
      logic los;
      int   cycles;
      logic exp_serdes;
      logic exp_pcs;
   } vec_t;

   vec_t tbl [13];

   // Reference model: sequence phases with their lengths taken from the timer exponents.
   typedef enum {PH_IDLE, PH_SRST, PH_T1, PH_CHK, PH_T2, PH_RUN} phase_t;
   phase_t     ph;
   int         el;
   logic [1:0] m_pll, m_cdr, m_los;
   logic       m_prev, m_serdes, m_pcs;

   task automatic model_reset();
      ph       = PH_IDLE;
      el       = 0;
      m_pll    = 2'b11;
      m_cdr    = 2'b11;
      m_los    = 2'b11;
      m_prev   = 1'b1;
      m_serdes = 1'b0;
      m_pcs    = 1'b1;
   endtask

   task automatic model_step(input logic pll, input logic cdr, input logic los);
      logic   plol, slos, ll, chg;
      phase_t nx;
      plol     = m_pll[1];
      slos     = m_los[1];
      ll       = m_cdr[1] | m_los[1];
      chg      = ll != m_prev;
      m_serdes = (ph == PH_SRST || ph == PH_T1);
      m_pcs    = (ph != PH_RUN);
      nx       = ph;
      if (plol && ph != PH_IDLE) nx = PH_IDLE;
      else begin
         case (ph)
            PH_IDLE: if (!plol && !slos) nx = PH_SRST;
            PH_SRST: begin nx = PH_T1; el = 1; end
            PH_T1:   if (el == T1_LEN) nx = PH_CHK; else el++;
            PH_CHK:  begin nx = PH_T2; el = 1; end
            PH_T2: begin
               if (chg) nx = PH_CHK;
               else if (el == T2_LEN) nx = ll ? PH_IDLE : PH_RUN;
               else el++;
            end
            PH_RUN:  if (ll) nx = PH_IDLE;
            default: nx = PH_IDLE;
         endcase
      end
      ph     = nx;
      m_pll  = {m_pll[0], pll};
      m_cdr  = {m_cdr[0], cdr};
      m_los  = {m_los[0], los};
      m_prev = ll;
   endtask

   initial begin
      int r;
      rst_n         = 1'b0;
      tx_pll_lol_qd = 1'b1;
      rx_cdr_lol_ch = 1'b1;
      rx_los_low_ch = 1'b1;
      @(negedge refclkdiv2);

      // Clean bring-up: serdes pulse of 6, pcs release 25 edges after WAIT_PLOL exit (edge 3).
      run_seq(40, -1, -1, -1, -1);
      check_int("bringup_serdes_rise", first_rise(1, 40), 4);
      check_int("bringup_serdes_width", count_hi(1, 40), 6);
      check_int("bringup_pcs_fall", first_pcs_low(40), 28);
      check_bit("bringup_pcs_hold", pc_tr[40], 1'b0);

      // CDR pulse mid-WAIT_T2 restarts qualification twice; release moves to edge 38.
      run_seq(45, -1, -1, 14, 16);
      check_int("cdr_toggle_pcs_fall", first_pcs_low(45), 38);
      check_int("cdr_toggle_serdes_width", count_hi(1, 45), 6);

      // Change arrives on the very edge timer2 saturates: change wins, expiry comes 18 later.
      run_seq(55, -1, -1, 25, 99);
      check_bit("chg_vs_expiry_no_early_pulse", sd_tr[29], 1'b0);
      check_int("chg_vs_expiry_second_rise", first_rise(11, 55), 47);
      check_int("chg_vs_expiry_pcs_never_low", first_pcs_low(55), -1);

      // CDR never locks: expiry returns to WAIT_PLOL and a fresh 6-cycle serdes pulse follows.
      run_seq(60, -1, -1, 0, 99);
      check_int("lol_expiry_second_rise", first_rise(11, 60), 29);
      check_int("lol_expiry_two_pulses", count_hi(1, 40), 12);
      check_int("lol_expiry_pcs_never_low", first_pcs_low(60), -1);

      // PLL loss in NORMAL: pcs back high on the 4th edge, no serdes pulse until PLL relocks.
      run_seq(70, 36, 60, -1, -1);
      check_bit("pll_loss_pcs_before", pc_tr[38], 1'b0);
      check_bit("pll_loss_pcs_after", pc_tr[39], 1'b1);
      check_int("pll_loss_no_serdes", count_hi(11, 63), 0);
      check_bit("pll_relock_serdes", sd_tr[64], 1'b1);

      // One-cycle PLL glitch together with CDR loss in WAIT_T2: PLL wins, so a reset pulse follows.
      run_seq(30, 15, 15, 15, 99);
      check_int("simul_plol_rise", first_rise(11, 30), 19);

      // Unencoded state from NORMAL: outputs take WAIT_PLOL values on the next edge.
      run_seq(35, -1, -1, -1, -1);
      check_bit("illegal_pre_pcs", rx_pcs_rst_ch_c, 1'b0);
      force dut.cs_q = 3'b111;
      tick();
      check_bit("illegal_serdes", rx_serdes_rst_ch_c, 1'b0);
      check_bit("illegal_pcs", rx_pcs_rst_ch_c, 1'b1);
      release dut.cs_q;

      // Asynchronous reset mid-NORMAL acts before any clock edge.
      run_seq(35, -1, -1, -1, -1);
      check_bit("async_pre_pcs", rx_pcs_rst_ch_c, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_bit("async_rst_serdes", rx_serdes_rst_ch_c, 1'b0);
      check_bit("async_rst_pcs", rx_pcs_rst_ch_c, 1'b1);
      @(negedge refclkdiv2);

      // Vector table: inputs held for 'cycles' edges, outputs checked afterwards.
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1,  3, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 40, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 40, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0,  3, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0,  5, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 30, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1,  3, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1,  1, 1'b0, 1'b1};
      for (int i = 0; i < 13; i++) begin
         rst_n         = tbl[i].rst_n;
         tx_pll_lol_qd = tbl[i].pll;
         rx_cdr_lol_ch = tbl[i].cdr;
         rx_los_low_ch = tbl[i].los;
         for (int c = 0; c < tbl[i].cycles; c++) tick();
         check_bit($sformatf("vec%0d_serdes", i), rx_serdes_rst_ch_c, tbl[i].exp_serdes);
         check_bit($sformatf("vec%0d_pcs", i), rx_pcs_rst_ch_c, tbl[i].exp_pcs);
      end

      // Randomized run against the model, with occasional asynchronous resets.
      tx_pll_lol_qd = 1'b1;
      rx_cdr_lol_ch = 1'b1;
      rx_los_low_ch = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         rst_n = !(cyc < 2 || $urandom_range(0, 499) == 0);
         if ($urandom_range(0, 63) == 0) tx_pll_lol_qd = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 23) == 0) rx_cdr_lol_ch = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 23) == 0) rx_los_low_ch = ($urandom_range(0, 3) == 0);
         if (!rst_n) model_reset();
         else model_step(tx_pll_lol_qd, rx_cdr_lol_ch, rx_los_low_ch);
         tick();
         r = cyc;
         check_bit($sformatf("rnd%0d_serdes", r), rx_serdes_rst_ch_c, m_serdes);
         check_bit($sformatf("rnd%0d_pcs", r), rx_pcs_rst_ch_c, m_pcs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
